// File: rtl/decode_cycle_if.sv
// Decode-to-execute bundle: instruction/PC inputs, writeback port, flush and
// the registered execute-stage outputs.
interface decode_cycle_if;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        RegWriteW;
    logic [4:0]  RDW;
    logic [31:0] ResultW;
    logic        FlushE;

    logic        RegWriteE;
    logic        MemWriteE;
    logic        JumpE;
    logic        BranchE;
    logic        ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E;
    logic [31:0] RD2E;
    logic [31:0] ImmExtE;
    logic [31:0] PCE;
    logic [31:0] PCPlus4E;
    logic [4:0]  RdE;
    logic [4:0]  Rs1E;
    logic [4:0]  Rs2E;

    modport master (
        output InstrD, PCD, PCPlus4D, RegWriteW, RDW, ResultW, FlushE,
        input  RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE,
               ALUControlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RdE, Rs1E, Rs2E
    );

    modport slave (
        input  InstrD, PCD, PCPlus4D, RegWriteW, RDW, ResultW, FlushE,
        output RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE,
               ALUControlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RdE, Rs1E, Rs2E
    );
endinterface

// File: rtl/decode_cycle.sv
// Decode stage: register file with writeback bypass, control/ALU decode,
// immediate generation and the decode->execute pipeline register.
module decode_cycle (
    input logic          clk,
    input logic          rst,
    decode_cycle_if.slave bus
);
    typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_J} imm_src_e;

    typedef struct packed {
        logic        reg_write;
        logic [1:0]  result_src;
        logic        mem_write;
        logic        jump;
        logic        branch;
        logic        alu_src;
        logic [2:0]  alu_control;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm_ext;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } ex_t;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_b5;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;

    logic        reg_write;
    logic [1:0]  result_src;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic        alu_src;
    logic [2:0]  alu_control;
    imm_src_e    imm_src;
    logic [31:0] imm_ext;
    logic [31:0] rd1;
    logic [31:0] rd2;

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];
    ex_t         ex_d;
    ex_t         ex_q;

    assign opcode    = bus.InstrD[6:0];
    assign funct3    = bus.InstrD[14:12];
    assign funct7_b5 = bus.InstrD[30];
    assign rs1_addr  = bus.InstrD[19:15];
    assign rs2_addr  = bus.InstrD[24:20];

    // Main control and ALU operation decode from opcode/funct fields
    always_comb begin
        reg_write   = 1'b0;
        result_src  = 2'b00;
        mem_write   = 1'b0;
        jump        = 1'b0;
        branch      = 1'b0;
        alu_src     = 1'b0;
        imm_src     = IMM_NONE;
        alu_control = 3'b000;
        unique case (opcode)
            7'b0000011: begin reg_write = 1'b1; result_src = 2'b01; alu_src = 1'b1; imm_src = IMM_I; end
            7'b0100011: begin mem_write = 1'b1; alu_src = 1'b1; imm_src = IMM_S; end
            7'b0110011: begin reg_write = 1'b1; end
            7'b1100011: begin branch = 1'b1; imm_src = IMM_B; alu_control = 3'b001; end
            7'b0010011: begin reg_write = 1'b1; alu_src = 1'b1; imm_src = IMM_I; end
            7'b1101111: begin reg_write = 1'b1; result_src = 2'b10; jump = 1'b1; imm_src = IMM_J; end
            default: ;
        endcase
        if (opcode == 7'b0110011 || opcode == 7'b0010011) begin
            unique case (funct3)
                3'b000:  alu_control = (opcode == 7'b0110011 && funct7_b5) ? 3'b001 : 3'b000;
                3'b010:  alu_control = 3'b101;
                3'b110:  alu_control = 3'b011;
                3'b111:  alu_control = 3'b010;
                default: alu_control = 3'b000;
            endcase
        end
    end

    // Sign-extended immediate for the selected instruction format
    always_comb begin
        unique case (imm_src)
            IMM_I:   imm_ext = {{20{bus.InstrD[31]}}, bus.InstrD[31:20]};
            IMM_S:   imm_ext = {{20{bus.InstrD[31]}}, bus.InstrD[31:25], bus.InstrD[11:7]};
            IMM_B:   imm_ext = {{20{bus.InstrD[31]}}, bus.InstrD[7], bus.InstrD[30:25], bus.InstrD[11:8], 1'b0};
            IMM_J:   imm_ext = {{12{bus.InstrD[31]}}, bus.InstrD[19:12], bus.InstrD[20], bus.InstrD[30:21], 1'b0};
            default: imm_ext = '0;
        endcase
    end

    // Register reads: x0 hard-wired to zero, same-cycle writeback bypassed
    always_comb begin
        if (rs1_addr == 5'd0)
            rd1 = '0;
        else if (bus.RegWriteW && bus.RDW == rs1_addr)
            rd1 = bus.ResultW;
        else
            rd1 = regs_q[rs1_addr];
        if (rs2_addr == 5'd0)
            rd2 = '0;
        else if (bus.RegWriteW && bus.RDW == rs2_addr)
            rd2 = bus.ResultW;
        else
            rd2 = regs_q[rs2_addr];
    end

    // Next register-file contents; writes to x0 are dropped
    always_comb begin
        regs_d = regs_q;
        if (bus.RegWriteW && bus.RDW != 5'd0)
            regs_d[bus.RDW] = bus.ResultW;
    end

    // Register file storage with synchronous clear
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < 32; i++)
                regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Next execute-stage entry, or a bubble when flushed
    always_comb begin
        ex_d = '0;
        if (!bus.FlushE) begin
            ex_d.reg_write   = reg_write;
            ex_d.result_src  = result_src;
            ex_d.mem_write   = mem_write;
            ex_d.jump        = jump;
            ex_d.branch      = branch;
            ex_d.alu_src     = alu_src;
            ex_d.alu_control = alu_control;
            ex_d.rd1         = rd1;
            ex_d.rd2         = rd2;
            ex_d.imm_ext     = imm_ext;
            ex_d.pc          = bus.PCD;
            ex_d.pc_plus4    = bus.PCPlus4D;
            ex_d.rd          = bus.InstrD[11:7];
            ex_d.rs1         = rs1_addr;
            ex_d.rs2         = rs2_addr;
        end
    end

    // Decode->execute pipeline register
    always_ff @(posedge clk) begin
        if (!rst)
            ex_q <= '0;
        else
            ex_q <= ex_d;
    end

    assign bus.RegWriteE   = ex_q.reg_write;
    assign bus.ResultSrcE  = ex_q.result_src;
    assign bus.MemWriteE   = ex_q.mem_write;
    assign bus.JumpE       = ex_q.jump;
    assign bus.BranchE     = ex_q.branch;
    assign bus.ALUSrcE     = ex_q.alu_src;
    assign bus.ALUControlE = ex_q.alu_control;
    assign bus.RD1E        = ex_q.rd1;
    assign bus.RD2E        = ex_q.rd2;
    assign bus.ImmExtE     = ex_q.imm_ext;
    assign bus.PCE         = ex_q.pc;
    assign bus.PCPlus4E    = ex_q.pc_plus4;
    assign bus.RdE         = ex_q.rd;
    assign bus.Rs1E        = ex_q.rs1;
    assign bus.Rs2E        = ex_q.rs2;
endmodule

// File: doc/decode_cycle.md
DECODE_CYCLE -- requirements
Module: decode_cycle

Interface
Parameters: none.
REQ-001 The block SHALL have clk, input, 1, rising-edge clock for all state.
REQ-002 The block SHALL have rst, input, 1, reset: synchronous, active-low; acts only on a rising clk edge while rst=0.
REQ-003 The block SHALL have InstrD, input, 32, instruction word from the fetch stage.
REQ-004 The block SHALL have PCD and PCPlus4D, input, 32 each, PC and PC+4 of InstrD.
REQ-005 The block SHALL have RegWriteW (input, 1), RDW (input, 5) and ResultW (input, 32), the writeback port into the register file.
REQ-006 The block SHALL have FlushE, input, 1, which turns the next execute-stage entry into a bubble.
REQ-007 The block SHALL have these registered outputs toward execute:
- RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE: 1 bit each
- ResultSrcE: 2 bits
- ALUControlE: 3 bits
- RD1E, RD2E, ImmExtE, PCE, PCPlus4E: 32 bits each
- RdE, Rs1E, Rs2E: 5 bits each

Function
REQ-008 Register file SHALL be 32x32, two combinational read ports (rs1=InstrD[19:15], rs2=InstrD[24:20]) and one write port.
REQ-009 The write port SHALL write ResultW to RDW on a rising clk edge when RegWriteW=1, rst=1 and RDW!=0.
REQ-010 Register x0 SHALL always read 0; writes to x0 SHALL be ignored.
REQ-011 Read bypass: when RegWriteW=1, RDW!=0 and RDW equals a read address, that port SHALL return ResultW in the same cycle.
REQ-012 Control decode on opcode InstrD[6:0] (RegWrite/ResultSrc/MemWrite/Jump/Branch/ALUSrc/ImmSrc):
- lw 0000011 -> 1/01/0/0/0/1/I
- sw 0100011 -> 0/xx(00)/1/0/0/1/S
- R 0110011 -> 1/00/0/0/0/0/-
- beq 1100011 -> 0/00/0/0/1/0/B
- I-ALU 0010011 -> 1/00/0/0/0/1/I
- jal 1101111 -> 1/10/0/1/0/0/J
REQ-013 Any other opcode SHALL drive all control signals to 0 (bubble).
REQ-014 ALUControl encoding SHALL be: 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-015 ALUControl selection:
- lw, sw, jal -> add
- beq -> sub
- R/I-ALU by funct3: 000 -> add, or sub when R-type with funct7[5]=1; 010 -> slt; 110 -> or; 111 -> and
- any other funct3 -> add
REQ-016 ImmExt SHALL be sign-extended from InstrD[31]:
- I: [31:20]
- S: {[31:25],[11:7]}
- B: {[31],[7],[30:25],[11:8],0}
- J: {[31],[19:12],[20],[30:21],0}
- none: 0
REQ-017 On each rising clk edge with rst=1 and FlushE=0, all E outputs SHALL capture their decode-side values (latency exactly one cycle); Rs1E/Rs2E/RdE SHALL come from InstrD[19:15]/[24:20]/[11:7].
REQ-018 On a rising edge with FlushE=1 (rst=1), all E outputs SHALL become 0; a register-file write in that same cycle SHALL still occur.

Reset
REQ-019 On a rising edge with rst=0, every E output SHALL become 0 and all 32 registers SHALL become 0.
REQ-020 A writeback requested during a reset cycle SHALL be discarded.
REQ-021 Reset SHALL take priority over FlushE and over writeback.
REQ-022 No output SHALL change asynchronously with rst.

Verification
REQ-023 Reset then lw: rst=0 two cycles, then InstrD=0x00402083 (lw x1,4(x0)), PCD=0x10 -> next edge: RegWriteE=1, ResultSrcE=01, ALUSrcE=1, ALUControlE=000, ImmExtE=4, RdE=1, PCE=0x10.
REQ-024 Writeback with bypass: RegWriteW=1, RDW=5, ResultW=0xDEADBEEF and InstrD=add x6,x5,x5 in the same cycle -> RD1E=RD2E=0xDEADBEEF next edge; a later read of x5 without writeback still returns 0xDEADBEEF.
REQ-025 x0 protection: write RDW=0, ResultW=0x1234 -> a subsequent read of x0 returns 0.
REQ-026 Immediate forms:
- sw imm -8 -> ImmExtE=0xFFFFFFF8
- beq offset -4 -> ImmExtE=0xFFFFFFFC, BranchE=1, ALUControlE=001
- jal +2048 -> ImmExtE=0x00000800, JumpE=1, ResultSrcE=10
REQ-027 Flush and illegal opcode:
- FlushE=1 with valid InstrD -> all E outputs 0 next edge while a concurrent writeback to x7 lands.
- InstrD=0xFFFFFFFF -> all E control 0.
REQ-028 Mid-stream reset: rst=0 for one edge between instructions -> E outputs 0 and previously written x5 reads 0 afterward.
